// File: rtl/tx_frame_scheduler.sv
// Frame buffer and transmit sequencer: commits complete length-prefixed host
// frames into a circular byte buffer and replays them over valid/ready.
module tx_frame_scheduler #(
    parameter int ADDR_W = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_en,
    input  logic        i_wr_abort,
    input  logic        i_clear_status,
    output logic        o_wr_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic [15:0] o_data_size,
    output logic [7:0]  o_frames_count,
    output logic [15:0] o_status
);
    localparam int          DEPTH   = 2**ADDR_W;
    localparam int          PW      = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN = 17'(DEPTH - 2);

    typedef enum logic [1:0] {W_LEN0, W_LEN1, W_DATA, W_SKIP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_HDR0, R_HDR1, R_DATA} rstate_t;

    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_rd_data_p1;
    wstate_t       r_wstate, w_wstate_nxt;
    rstate_t       r_rstate, w_rstate_nxt;
    logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_nxt, w_commit_ptr_nxt, w_rd_ptr_nxt;
    logic [PW-1:0] w_used, w_size;
    logic [7:0]    r_len_lo, w_len_lo_nxt;
    logic [15:0]   r_remain, w_remain_nxt;
    logic [15:0]   r_count, w_count_nxt;
    logic [15:0]   w_len;
    logic [7:0]    r_frames, r_drops, w_drops_base;
    logic [3:0]    r_sticky, w_evt;
    logic          w_full, w_empty, w_store, w_commit, w_drop_evt, w_xfer, w_last_xfer;

    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_size      = r_commit_ptr - r_rd_ptr;
    assign w_full      = (w_used == PW'(DEPTH));
    assign w_empty     = (w_used == '0);
    assign w_len       = {i_wr_data, r_len_lo};

    // r_remain counts payload bytes in W_DATA and bytes to discard in W_SKIP
    always_comb begin
        w_wstate_nxt     = r_wstate;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_len_lo_nxt     = r_len_lo;
        w_remain_nxt     = r_remain;
        w_store          = 1'b0;
        w_commit         = 1'b0;
        w_drop_evt       = 1'b0;
        w_evt            = 4'b0000;
        if (i_wr_abort && (r_wstate != W_LEN0)) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_evt[3]     = 1'b1;
            w_drop_evt   = 1'b1;
            w_wstate_nxt = W_LEN0;
        end else if (i_wr_en) begin
            if (r_wstate == W_SKIP) begin
                w_remain_nxt = r_remain - 16'd1;
                if (r_remain == 16'd1) w_wstate_nxt = W_LEN0;
            end else if (w_full) begin
                w_wr_ptr_nxt = r_commit_ptr;
                w_evt[0]     = 1'b1;
                w_drop_evt   = (r_wstate != W_LEN0);
                if ((r_wstate == W_DATA) && (r_remain != 16'd1)) begin
                    w_remain_nxt = r_remain - 16'd1;
                    w_wstate_nxt = W_SKIP;
                end else begin
                    w_wstate_nxt = W_LEN0;
                end
            end else begin
                w_store      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
                case (r_wstate)
                    W_LEN0: begin
                        w_len_lo_nxt = i_wr_data;
                        w_wstate_nxt = W_LEN1;
                    end
                    W_LEN1: begin
                        if (w_len == 16'd0) begin
                            w_evt[1]     = 1'b1;
                            w_drop_evt   = 1'b1;
                            w_wr_ptr_nxt = r_commit_ptr;
                            w_wstate_nxt = W_LEN0;
                        end else if ({1'b0, w_len} > MAX_LEN) begin
                            w_evt[2]     = 1'b1;
                            w_drop_evt   = 1'b1;
                            w_wr_ptr_nxt = r_commit_ptr;
                            w_remain_nxt = w_len;
                            w_wstate_nxt = W_SKIP;
                        end else begin
                            w_remain_nxt = w_len;
                            w_wstate_nxt = W_DATA;
                        end
                    end
                    W_DATA: begin
                        w_remain_nxt = r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            w_commit         = 1'b1;
                            w_commit_ptr_nxt = r_wr_ptr + PW'(1);
                            w_wstate_nxt     = W_LEN0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read address is the next rd_ptr, so r_rd_data_p1 always mirrors mem[rd_ptr]
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_last_xfer  = 1'b0;
        w_xfer       = (r_rstate == R_DATA) && i_tx_ready;
        case (r_rstate)
            R_IDLE: if (r_frames != 8'd0) w_rstate_nxt = R_HDR0;
            R_HDR0: begin
                w_count_nxt  = {8'h00, r_rd_data_p1};
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
                w_rstate_nxt = R_HDR1;
            end
            R_HDR1: begin
                w_count_nxt  = {r_rd_data_p1, r_count[7:0]};
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
                w_rstate_nxt = R_DATA;
            end
            R_DATA: if (w_xfer) begin
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
                w_count_nxt  = r_count - 16'd1;
                if (r_count == 16'd1) begin
                    w_last_xfer  = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: ;
        endcase
    end

    assign w_drops_base = i_clear_status ? 8'd0 : r_drops;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wstate     <= W_LEN0;
            r_rstate     <= R_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_len_lo     <= 8'd0;
            r_remain     <= 16'd0;
            r_count      <= 16'd0;
            r_frames     <= 8'd0;
            r_drops      <= 8'd0;
            r_sticky     <= 4'b0000;
        end else begin
            r_wstate     <= w_wstate_nxt;
            r_rstate     <= w_rstate_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_len_lo     <= w_len_lo_nxt;
            r_remain     <= w_remain_nxt;
            r_count      <= w_count_nxt;
            case ({w_commit, w_last_xfer})
                2'b10:   r_frames <= r_frames + 8'd1;
                2'b01:   r_frames <= r_frames - 8'd1;
                default: r_frames <= r_frames;
            endcase
            r_sticky <= (i_clear_status ? 4'b0000 : r_sticky) | w_evt;
            if (w_drop_evt)
                r_drops <= (w_drops_base == 8'hFF) ? 8'hFF : w_drops_base + 8'd1;
            else
                r_drops <= w_drops_base;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_store) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        r_rd_data_p1 <= r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
    end

    assign o_wr_ready     = !w_full;
    assign o_tx_valid     = (r_rstate == R_DATA);
    assign o_tx_last      = (r_rstate == R_DATA) && (r_count == 16'd1);
    assign o_tx_data      = o_tx_valid ? r_rd_data_p1 : 8'd0;
    assign o_data_size    = 16'(w_size);
    assign o_frames_count = r_frames;
    assign o_status       = {r_drops, r_sticky, w_empty, w_full,
                             (r_rstate != R_IDLE), (r_wstate != W_LEN0)};

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: directed steps plus a randomized frame mix,
// checked against a frame-level queue model of the transmit stream.
module tb_tx_frame_scheduler;
    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_wr_data = 8'd0;
    logic        i_wr_en = 1'b0;
    logic        i_wr_abort = 1'b0;
    logic        i_clear_status = 1'b0;
    logic        o_wr_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_tx_last;
    logic        i_tx_ready = 1'b0;
    logic [15:0] o_data_size;
    logic [7:0]  o_frames_count;
    logic [15:0] o_status;

    tx_frame_scheduler #(.ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_data(i_wr_data), .i_wr_en(i_wr_en),
        .i_wr_abort(i_wr_abort), .i_clear_status(i_clear_status),
        .o_wr_ready(o_wr_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .o_tx_last(o_tx_last), .i_tx_ready(i_tx_ready), .o_data_size(o_data_size),
        .o_frames_count(o_frames_count), .o_status(o_status)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;          // 0 low, 1 high, 2 random, 3 toggle

    // Model: expected payload stream and bytes held by each outstanding frame
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    int         mdl_sizes[$];
    logic [7:0] pay_q[$];
    logic [3:0] mdl_sticky = 4'b0000;
    int         mdl_drops = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        case (rdy_mode)
            0: i_tx_ready = 1'b0;
            1: i_tx_ready = 1'b1;
            2: i_tx_ready = 1'($urandom_range(0, 1));
            default: i_tx_ready = ~i_tx_ready;
        endcase
    endtask

    task automatic wb(input logic [7:0] b);
        i_wr_en   = 1'b1;
        i_wr_data = b;
        step();
        i_wr_en   = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic model_commit();
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            exp_last_q.push_back(i == pay_q.size() - 1);
        end
        mdl_sizes.push_back(pay_q.size() + 2);
    endtask

    task automatic send_frame(input bit gaps);
        logic [15:0] l16;
        l16 = 16'(pay_q.size());
        wb(l16[7:0]);
        wb(l16[15:8]);
        foreach (pay_q[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) step();
            wb(pay_q[i]);
        end
        model_commit();
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_last_q.delete();
        mdl_sizes.delete();
    endtask

    task automatic clear_status();
        i_clear_status = 1'b1;
        step();
        i_clear_status = 1'b0;
        mdl_sticky = 4'b0000;
        mdl_drops  = 0;
    endtask

    function automatic int occupancy();
        int s = 0;
        foreach (mdl_sizes[i]) s += mdl_sizes[i];
        return s;
    endfunction

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || mdl_sizes.size() != 0) && g < 1000) begin
            step();
            g++;
        end
        checks++;
        assert (g < 1000) else begin
            errors++;
            $error("FAIL %s_drain observed=%0d bytes pending expected=0", tag, exp_q.size());
        end
    endtask

    task automatic wait_space(input int need);
        int g = 0;
        while ((occupancy() + need > DEPTH) && g < 1000) begin
            step();
            g++;
        end
        checks++;
        assert (g < 1000) else begin
            errors++;
            $error("FAIL space_wait observed=%0d bytes used expected<=%0d", occupancy(), DEPTH - need);
        end
    endtask

    // Transmit monitor: transfers happen at the posedge following a valid&&ready negedge
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;
    always @(negedge i_clk) begin
        if (i_rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk("tx_hold", {6'd0, o_tx_valid, o_tx_last, o_tx_data}, {6'd0, 1'b1, hold_last, hold_data});
            hold_pend = 1'b0;
            if (o_tx_valid === 1'b1) begin
                if (i_tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected", {7'd0, o_tx_last, o_tx_data}, 16'hFFFF);
                    end else begin
                        logic [7:0] eb;
                        bit         el;
                        eb = exp_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk("tx_byte", {7'd0, o_tx_last, o_tx_data}, {7'd0, el, eb});
                        if (el && mdl_sizes.size() != 0) void'(mdl_sizes.pop_front());
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_data = o_tx_data;
                    hold_last = o_tx_last;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int op, len, k;
    logic [15:0] l16;

    initial begin
        // Reset values
        step();
        step();
        chk("rst_valid", 16'(o_tx_valid), 16'd0);
        chk("rst_last", 16'(o_tx_last), 16'd0);
        chk("rst_data", 16'(o_tx_data), 16'd0);
        chk("rst_size", o_data_size, 16'd0);
        chk("rst_frames", 16'(o_frames_count), 16'd0);
        chk("rst_status", o_status, 16'h0008);
        chk("rst_wr_ready", 16'(o_wr_ready), 16'd1);
        i_rst = 1'b0;
        step();

        // Basic frame and first-byte latency
        rdy_mode = 1;
        i_tx_ready = 1'b1;
        pay_q = '{8'hAA, 8'hBB};
        send_frame(1'b0);
        chk("basic_frames", 16'(o_frames_count), 16'd1);
        chk("basic_size", o_data_size, 16'd4);
        chk("basic_valid_e1", 16'(o_tx_valid), 16'd0);
        step();
        step();
        chk("basic_valid_e2", 16'(o_tx_valid), 16'd0);
        step();
        chk("basic_first", {7'd0, o_tx_valid, o_tx_data}, {7'd0, 1'b1, 8'hAA});
        chk("basic_first_last", 16'(o_tx_last), 16'd0);
        wait_drain("basic");
        chk("basic_frames_end", 16'(o_frames_count), 16'd0);
        chk("basic_status_end", o_status, 16'h0008);

        // Zero-length frame is discarded
        wb(8'h00);
        wb(8'h00);
        mdl_sticky[1] = 1'b1;
        mdl_drops++;
        chk("zlen_bit", 16'(o_status[5]), 16'd1);
        chk("zlen_frames", 16'(o_frames_count), 16'd0);
        pay_q = '{8'h55};
        send_frame(1'b0);
        chk("zlen_next_frames", 16'(o_frames_count), 16'd1);
        wait_drain("zlen");

        // Fill to full with the transmitter stalled
        rdy_mode = 0;
        i_tx_ready = 1'b0;
        fill_rand(DEPTH - 2);
        send_frame(1'b0);
        chk("full_wr_ready", 16'(o_wr_ready), 16'd0);
        chk("full_size", o_data_size, 16'(DEPTH));
        chk("full_frames", 16'(o_frames_count), 16'd1);
        chk("full_bit", 16'(o_status[2]), 16'd1);
        wb(8'h01);
        wb(8'h00);
        chk("ovf_bit", 16'(o_status[4]), 16'd1);
        chk("ovf_wstate", 16'(o_status[0]), 16'd0);
        rdy_mode = 1;
        wait_drain("ovf");
        chk("ovf_size_end", o_data_size, 16'd0);
        chk("ovf_frames_end", 16'(o_frames_count), 16'd0);

        // Abort mid-frame
        clear_status();
        wb(8'h05);
        wb(8'h00);
        wb(8'h11);
        wb(8'h22);
        i_wr_abort = 1'b1;
        step();
        i_wr_abort = 1'b0;
        chk("abort_status", o_status, 16'h0188);
        chk("abort_size", o_data_size, 16'd0);
        pay_q = '{8'h33};
        send_frame(1'b0);
        wait_drain("abort");

        // Commit on the same edge as an earlier frame's last transfer
        pay_q = '{8'h77};
        wb(8'h01);
        wb(8'h00);
        wb(8'h77);
        model_commit();
        step();
        pay_q = '{8'h88};
        wb(8'h01);
        wb(8'h00);
        wb(8'h88);
        model_commit();
        chk("simul_frames", 16'(o_frames_count), 16'd1);
        chk("simul_size", o_data_size, 16'd3);
        wait_drain("simul");

        // Ready toggling every cycle
        rdy_mode = 3;
        fill_rand(12);
        send_frame(1'b1);
        wait_drain("toggle");

        // Reset in the middle of both write and read activity
        rdy_mode = 0;
        i_tx_ready = 1'b0;
        fill_rand(5);
        send_frame(1'b0);
        wb(8'h06);
        wb(8'h00);
        wb(8'h9A);
        wb(8'h9B);
        chk("mid_busy", {14'd0, o_status[1:0]}, 16'd3);
        chk("mid_valid", 16'(o_tx_valid), 16'd1);
        i_rst = 1'b1;
        #1;
        model_clear();
        mdl_sticky = 4'b0000;
        mdl_drops = 0;
        chk("mid_rst_valid", 16'(o_tx_valid), 16'd0);
        chk("mid_rst_last", 16'(o_tx_last), 16'd0);
        chk("mid_rst_data", 16'(o_tx_data), 16'd0);
        chk("mid_rst_size", o_data_size, 16'd0);
        chk("mid_rst_frames", 16'(o_frames_count), 16'd0);
        chk("mid_rst_status", o_status, 16'h0008);
        chk("mid_rst_wr_ready", 16'(o_wr_ready), 16'd1);
        step();
        i_rst = 1'b0;
        rdy_mode = 1;
        step();
        pay_q = '{8'hC1, 8'hC2};
        send_frame(1'b0);
        wait_drain("post_rst");
        chk("post_rst_status", o_status, 16'h0008);

        // Randomized frame mix with a random transmitter
        clear_status();
        rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                len = $urandom_range(2, 10);
                wait_space(len + 2);
                k = $urandom_range(0, len - 1);
                l16 = 16'(len);
                wb(l16[7:0]);
                wb(l16[15:8]);
                for (int i = 0; i < k; i++) wb(8'($urandom));
                i_wr_abort = 1'b1;
                step();
                i_wr_abort = 1'b0;
                mdl_sticky[3] = 1'b1;
                mdl_drops++;
            end else if (op == 1) begin
                len = $urandom_range(DEPTH - 1, DEPTH + 4);
                wait_space(2);
                l16 = 16'(len);
                wb(l16[7:0]);
                wb(l16[15:8]);
                for (int i = 0; i < len; i++) wb(8'($urandom));
                mdl_sticky[2] = 1'b1;
                mdl_drops++;
            end else begin
                len = $urandom_range(1, 10);
                fill_rand(len);
                wait_space(len + 2);
                send_frame(1'b1);
            end
            chk("rand_frames", 16'(o_frames_count), 16'(mdl_sizes.size()));
        end
        wait_drain("rand");
        chk("rand_size_end", o_data_size, 16'd0);
        chk("rand_status_hi", {4'd0, o_status[15:4]},
            {4'd0, 8'((mdl_drops > 255) ? 255 : mdl_drops), mdl_sticky});
        chk("rand_status_lo", {12'd0, o_status[3:0]}, 16'h0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Frame buffer and transmit sequencer between the host byte interface and the byte-wide line transmitter. It accepts length-prefixed frames one byte at a time, holds them in an internal circular buffer, and commits each frame only when it is complete. It then replays committed frames in order to the transmitter over a valid/ready handshake. It also drives the transmitter size, frame-count and status words that the host register map reads back.

## Interface
- `ADDR_W`, default 9: buffer address width; depth `DEPTH = 2**ADDR_W` bytes.
- `i_clk`, input, 1: clock. All logic runs on the rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_wr_data`, input, 8: host byte.
- `i_wr_en`, input, 1: host byte strobe, one byte per cycle.
- `i_wr_abort`, input, 1: discard the frame currently being written.
- `i_clear_status`, input, 1: clears the sticky status bits and the drop counter.
- `o_wr_ready`, output, 1: the buffer has at least one free byte.
- `o_tx_data`, output, 8: payload byte for the transmitter.
- `o_tx_valid`, output, 1: `o_tx_data` is valid.
- `o_tx_last`, output, 1: the current byte is the last byte of its frame.
- `i_tx_ready`, input, 1: the transmitter accepts the byte.
- `o_data_size`, output, 16: committed bytes held in the buffer, headers included.
- `o_frames_count`, output, 8: number of committed frames not yet fully sent.
- `o_status`, output, 16: status word; bit layout under Operation.

## Operation
**Frame format**
- Byte 0 is len[7:0], byte 1 is len[15:8], then `len` payload bytes.
- Both header bytes are stored in the buffer ahead of the payload.

**Pointers**
- `wr_ptr`, `commit_ptr` and `rd_ptr` are each ADDR_W+1 bits and wrap modulo 2·DEPTH.
- used = `wr_ptr` − `rd_ptr`.
- full = (used == DEPTH); `o_wr_ready` = !full.

**Write FSM**
- W_LEN0: store the byte, go to W_LEN1.
- W_LEN1: store the byte and check len.
  - len == 0: set zerolen, rewind, go to W_LEN0.
  - len > DEPTH−2: set oversize, rewind, go to W_SKIP with skip = len.
  - otherwise: go to W_DATA with remaining = len.
- W_DATA: store each byte and decrement remaining.
  - The byte that brings remaining to 0 commits the frame: `commit_ptr` ← `wr_ptr`+1, `o_frames_count` +1, go to W_LEN0.
- W_SKIP: consume skip bytes without storing them, then go to W_LEN0.
- Write while full, in any storing state:
  - The byte is dropped, overflow is set and the frame is rewound.
  - In W_LEN0: go to W_LEN0.
  - In W_LEN1: go to W_LEN0.
  - In W_DATA: go to W_SKIP with skip = remaining − 1. If that is 0, go to W_LEN0.
- Rewind means `wr_ptr` ← `commit_ptr`. Every rewind of a partial frame increments the drop counter.
- `i_wr_abort` in any state other than W_LEN0: rewind, set abort, increment the drop counter, go to W_LEN0.
  - Abort has priority over a simultaneous `i_wr_en`; that byte is dropped.
  - Abort in W_LEN0 has no effect.

**Read FSM**
- R_IDLE: go to R_HDR0 when `o_frames_count` != 0.
- R_HDR0 and R_HDR1: read one header byte each, advance `rd_ptr`, assemble the 16-bit count.
- R_DATA: present payload bytes.
  - A byte transfers when `o_tx_valid` && `i_tx_ready`.
  - On each transfer, advance `rd_ptr` and decrement count.
  - `o_tx_last` = (count == 1).
  - When the last byte transfers: `o_frames_count` −1, go to R_IDLE.
- The read side never passes `commit_ptr`.
- `o_tx_valid`, `o_tx_data` and `o_tx_last` hold steady while `i_tx_ready` is low.

**Counters**
- `o_data_size` = `commit_ptr` − `rd_ptr`, zero-extended to 16 bits.
- `o_frames_count` on a commit and a last-byte transfer in the same cycle: unchanged.

**o_status bits**
- [0] write FSM not in W_LEN0.
- [1] read FSM not in R_IDLE.
- [2] full.
- [3] empty (used == 0).
- [4] overflow, sticky.
- [5] zerolen, sticky.
- [6] oversize, sticky.
- [7] abort, sticky.
- [15:8] drop counter, saturates at 255.

**Status clear**
- `i_clear_status` clears bits [7:4] and [15:8].
- If a sticky event occurs in the same cycle, the event wins.

## Timing
**Reset values**
- Both FSMs are in their idle states (W_LEN0, R_IDLE).
- All pointers are 0.
- `o_tx_valid` = 0, `o_tx_last` = 0, `o_tx_data` = 0.
- `o_data_size` = 0, `o_frames_count` = 0.
- `o_status` = 16'h0008 (empty).
- `o_wr_ready` = 1.

**Reset mid-operation**
- All frames are discarded, including committed ones.
- No output glitch beyond the asynchronous clear.

**Buffer**
- Registered read. Read data appears one cycle after the address is issued.

**Latencies**
- A commit is visible in `o_frames_count` and `o_data_size` on the edge that stores the final payload byte.
- From R_IDLE, `o_tx_valid` rises exactly 3 edges after `o_frames_count` becomes nonzero.
- Back-to-back frames: the next frame's first byte appears 3 edges after the previous frame's last-byte transfer.
- Sustained read throughput is one byte per cycle while `i_tx_ready` stays high.

**Pointer timing**
- `o_wr_ready` is combinational from the pointer registers.
- Bytes freed by reads are available to writes on the next cycle.

## Test plan
- Reset, then write 02 00 AA BB → `o_frames_count` = 1, `o_data_size` = 4, then AA (last=0) and BB (last=1) with `i_tx_ready` held high; afterwards `o_frames_count` = 0 and `o_status` = 16'h0008.
- Write 00 00, then 01 00 55 → zerolen bit set and no frame for the first; `o_frames_count` = 1 and 55 is transmitted.
- ADDR_W=4 with `i_tx_ready` = 0: write 0E 00 plus 14 bytes (buffer full, `o_wr_ready` = 0), start a second frame 01 00 → the byte at full is dropped and overflow is set; after the first frame drains, `o_data_size` = 0 and `o_frames_count` = 0.
- Write 05 00 11 22, assert `i_wr_abort` → `wr_ptr` rewinds, status bit 7 set, [15:8] = 1; a following frame 01 00 33 sends only 33.
- Commit a frame on the same edge the read side transfers the last byte of an earlier frame → `o_frames_count` unchanged; `i_tx_ready` toggling every cycle keeps the data stable with no skipped or duplicated bytes.
- Assert `i_rst` while in W_DATA and R_DATA → all outputs return to their reset values immediately; a new frame then sends correctly.
